// File: rtl/paddle_reader_multi_if.sv
// Paddle reader bus: raster timing and paddle pins in,
// published positions, presence flags and update strobe out.
interface paddle_reader_multi_if #(
  parameter int NCH   = 2,
  parameter int VBITS = 9,
  parameter int PBITS = 8
);
  logic [VBITS-1:0]     vpos;
  logic                 vsync;
  logic [NCH-1:0]       paddle;
  logic [NCH*PBITS-1:0] pos;
  logic [NCH-1:0]       present;
  logic                 update;

  // Timing/pin side drives the raster and paddles.
  modport master (
    output vpos,
    output vsync,
    output paddle,
    input  pos,
    input  present,
    input  update
  );

  // Reader side consumes them and publishes results.
  modport slave (
    input  vpos,
    input  vsync,
    input  paddle,
    output pos,
    output present,
    output update
  );
endinterface

// File: rtl/paddle_reader_multi.sv
// Multi-channel paddle capture: latches the scanline of each
// paddle's first rise per frame and publishes it on vsync.
module paddle_reader_multi #(
  parameter int NCH    = 2,
  parameter int VBITS  = 9,
  parameter int PBITS  = 8,
  parameter int VMIN   = 0,
  parameter int FILTER = 0
) (
  input logic clk,
  input logic reset,
  paddle_reader_multi_if.slave bus
);

  logic [NCH-1:0] s1_q;
  logic [NCH-1:0] s2_q;
  logic [NCH-1:0] s3_q;
  logic           vsync_d_q;

  logic [NCH-1:0] edge_w;
  logic           vs_rise_w;

  logic [31:0]      off_w;
  logic             sat_w;
  logic [PBITS-1:0] raw_w;

  logic [NCH-1:0][PBITS-1:0] cap_q;
  logic [NCH-1:0][PBITS-1:0] pos_q;
  logic [NCH-1:0][PBITS-1:0] pos_d;
  logic [PBITS:0]            sum_w [NCH];

  logic [NCH-1:0] captured_q;
  logic [NCH-1:0] captured_d;
  logic [NCH-1:0] present_q;
  logic           update_q;

  // Rising edges of synchronised paddles and of in-domain vsync.
  always_comb begin
    edge_w    = s2_q & ~s3_q;
    vs_rise_w = bus.vsync & ~vsync_d_q;
  end

  // Offset-corrected, saturated scanline shared by all channels.
  always_comb begin
    if (32'(bus.vpos) < 32'(VMIN)) begin
      off_w = 32'd0;
    end else begin
      off_w = 32'(bus.vpos) - 32'(VMIN);
    end
    sat_w = |(off_w >> PBITS);
    raw_w = sat_w ? '1 : off_w[PBITS-1:0];
  end

  // Value to publish per channel: raw capture or rounded average.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      sum_w[i] = {1'b0, pos_q[i]} + {1'b0, cap_q[i]}
               + (PBITS+1)'(1);
      if (FILTER != 0) begin
        pos_d[i] = PBITS'(sum_w[i] >> 1);
      end else begin
        pos_d[i] = cap_q[i];
      end
    end
  end

  // Frame close frees every channel before this cycle's edge is
  // considered, so an edge on the vsync cycle opens the new frame.
  always_comb begin
    captured_d = vs_rise_w ? '0 : captured_q;
  end

  // Two-flop synchroniser plus edge history; vsync history.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q      <= '1;
      s2_q      <= '1;
      s3_q      <= '1;
      vsync_d_q <= 1'b1;
    end else begin
      s1_q      <= bus.paddle;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      vsync_d_q <= bus.vsync;
    end
  end

  // First edge per frame latches the scanline; later ones ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      cap_q      <= '0;
      captured_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (edge_w[i] && !captured_d[i]) begin
          cap_q[i]      <= raw_w;
          captured_q[i] <= 1'b1;
        end else begin
          captured_q[i] <= captured_d[i];
        end
      end
    end
  end

  // Publish positions and presence at the start of vsync.
  always_ff @(posedge clk) begin
    if (reset) begin
      pos_q     <= '0;
      present_q <= '0;
      update_q  <= 1'b0;
    end else begin
      update_q <= vs_rise_w;
      if (vs_rise_w) begin
        present_q <= captured_q;
        for (int i = 0; i < NCH; i++) begin
          if (captured_q[i]) begin
            pos_q[i] <= pos_d[i];
          end
        end
      end
    end
  end

  assign bus.pos     = pos_q;
  assign bus.present = present_q;
  assign bus.update  = update_q;

endmodule

// File: tb/tb_paddle_reader_multi.sv
// Bench for paddle_reader_multi: three configurations share one
// stimulus stream and are compared every cycle against a model.
module tb_paddle_reader_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic [8:0] vpos;
  logic       vsync;
  logic [1:0] paddle;

  int ncmp = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  paddle_reader_multi_if #(.NCH(2), .VBITS(9), .PBITS(8)) ifa ();
  paddle_reader_multi_if #(.NCH(2), .VBITS(9), .PBITS(8)) ifb ();
  paddle_reader_multi_if #(.NCH(2), .VBITS(9), .PBITS(8)) ifc ();

  assign ifa.vpos   = vpos;
  assign ifa.vsync  = vsync;
  assign ifa.paddle = paddle;
  assign ifb.vpos   = vpos;
  assign ifb.vsync  = vsync;
  assign ifb.paddle = paddle;
  assign ifc.vpos   = vpos;
  assign ifc.vsync  = vsync;
  assign ifc.paddle = paddle;

  paddle_reader_multi #(
    .NCH(2), .VBITS(9), .PBITS(8), .VMIN(0), .FILTER(0)
  ) ua (.clk(clk), .reset(rst), .bus(ifa));

  paddle_reader_multi #(
    .NCH(2), .VBITS(9), .PBITS(8), .VMIN(16), .FILTER(0)
  ) ub (.clk(clk), .reset(rst), .bus(ifb));

  paddle_reader_multi #(
    .NCH(2), .VBITS(9), .PBITS(8), .VMIN(0), .FILTER(1)
  ) uc (.clk(clk), .reset(rst), .bus(ifc));

  // Reference model: per configuration, per channel.
  int vmin_k [3] = '{0, 16, 0};
  int filt_k [3] = '{0, 0, 1};

  int m_cap  [3][2];
  int m_pos  [3][2];
  bit m_got  [3][2];
  bit m_pres [3][2];
  bit m_upd  [3];

  // Paddle levels seen at previous edges (index 0 = newest).
  bit [1:0] seen [$];
  bit       vs_prev;

  function automatic int raw_of(int v, int vmin);
    int r;
    r = v - vmin;
    if (r < 0) r = 0;
    if (r > 255) r = 255;
    return r;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_upd[k] = 0;
      for (int c = 0; c < 2; c++) begin
        m_cap[k][c]  = 0;
        m_pos[k][c]  = 0;
        m_got[k][c]  = 0;
        m_pres[k][c] = 0;
      end
    end
    seen    = '{2'b11, 2'b11, 2'b11};
    vs_prev = 1'b1;
  endtask

  // A rise applied two edges ago is captured with today's vpos.
  task automatic model_step();
    bit       vr;
    bit [1:0] ed;
    if (rst) begin
      model_reset();
      return;
    end
    vr = vsync && !vs_prev;
    ed = seen[1] & ~seen[2];
    for (int k = 0; k < 3; k++) begin
      m_upd[k] = vr;
      for (int c = 0; c < 2; c++) begin
        if (vr) begin
          m_pres[k][c] = m_got[k][c];
          if (m_got[k][c]) begin
            if (filt_k[k] != 0)
              m_pos[k][c] = (m_pos[k][c] + m_cap[k][c] + 1) / 2;
            else
              m_pos[k][c] = m_cap[k][c];
          end
          m_got[k][c] = 0;
        end
        if (ed[c] && !m_got[k][c]) begin
          m_cap[k][c] = raw_of(int'(vpos), vmin_k[k]);
          m_got[k][c] = 1;
        end
      end
    end
    seen.push_front(paddle);
    void'(seen.pop_back());
    vs_prev = vsync;
  endtask

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    ncmp++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0d exp=%0d t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic cmp_k(int k, logic u, logic [1:0] pr,
                       logic [15:0] ps);
    chk($sformatf("upd%0d", k), 32'(u), 32'(m_upd[k]));
    chk($sformatf("pres%0d", k), 32'(pr),
        32'({m_pres[k][1], m_pres[k][0]}));
    chk($sformatf("pos%0d", k), 32'(ps),
        32'({8'(m_pos[k][1]), 8'(m_pos[k][0])}));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    cmp_k(0, ifa.update, ifa.present, ifa.pos);
    cmp_k(1, ifb.update, ifb.present, ifb.pos);
    cmp_k(2, ifc.update, ifc.present, ifc.pos);
  endtask

  task automatic drive(int v, bit vs, bit [1:0] p);
    vpos   = 9'(v);
    vsync  = vs;
    paddle = p;
    tick();
  endtask

  // One frame: channel rises at line r (-1 never), ch0 may dip
  // for two lines at g0 to make a second edge, then vsync.
  task automatic frame(int nl, int r0, int r1, int g0, int vsl);
    for (int v = 0; v < nl; v++) begin
      bit [1:0] p;
      p[0] = (r0 >= 0) && (v >= r0)
           && !((g0 >= 0) && (v >= g0) && (v < g0 + 2));
      p[1] = (r1 >= 0) && (v >= r1);
      drive(v, 1'b0, p);
    end
    for (int i = 0; i < vsl; i++) drive(nl, 1'b1, 2'b00);
    drive(nl, 1'b0, 2'b00);
  endtask

  task automatic do_reset(bit vs, bit [1:0] p);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) drive(0, vs, p);
    rst = 1'b0;
  endtask

  initial begin
    int v;
    int gap;
    int vsl;
    int ucount;
    bit [1:0] p;

    rst    = 1'b1;
    vpos   = '0;
    vsync  = 1'b0;
    paddle = '0;
    model_reset();
    do_reset(1'b0, 2'b00);
    chk("rst_pos", 32'(ifa.pos), 32'd0);
    chk("rst_pres", 32'(ifa.present), 32'd0);
    chk("rst_upd", 32'(ifa.update), 32'd0);

    frame(120, 98, 35, -1, 3);
    chk("t1_pos", 32'(ifa.pos), 32'({8'd37, 8'd100}));
    chk("t1_pres", 32'(ifa.present), 32'd3);

    frame(120, 48, 35, 55, 2);
    chk("t2_pos0", 32'(ifa.pos[7:0]), 32'd50);

    frame(80, 10, -1, -1, 1);
    chk("t3_pos1", 32'(ifa.pos[15:8]), 32'd37);
    chk("t3_pres", 32'(ifa.present), 32'd1);

    frame(310, 8, -1, -1, 2);
    chk("t4_b0", 32'(ifb.pos[7:0]), 32'd0);
    frame(310, 14, -1, -1, 2);
    chk("t4_b1", 32'(ifb.pos[7:0]), 32'd0);
    chk("t4_a1", 32'(ifa.pos[7:0]), 32'd16);
    frame(310, 298, -1, -1, 2);
    chk("t4_b2", 32'(ifb.pos[7:0]), 32'd255);

    do_reset(1'b0, 2'b00);
    frame(210, 198, -1, -1, 2);
    chk("t5_avg1", 32'(ifc.pos[7:0]), 32'd100);
    frame(60, 49, -1, -1, 2);
    chk("t5_avg2", 32'(ifc.pos[7:0]), 32'd76);
    for (int i = 0; i < 10; i++) frame(270, 260, -1, -1, 2);
    chk("t5_sat", 32'(ifc.pos[7:0]), 32'd255);

    for (int i = 0; i < 5; i++) drive(i, 1'b0, 2'b00);
    drive(5, 1'b0, 2'b01);
    drive(6, 1'b0, 2'b01);
    drive(7, 1'b1, 2'b01);
    chk("t6_pres", 32'(ifa.present), 32'd0);
    for (int i = 0; i < 3; i++) drive(8, 1'b1, 2'b01);
    for (int i = 9; i < 20; i++) drive(i, 1'b0, 2'b01);
    drive(20, 1'b1, 2'b01);
    chk("t6_pos0", 32'(ifa.pos[7:0]), 32'd7);
    chk("t6_pres2", 32'(ifa.present), 32'd1);
    drive(21, 1'b0, 2'b00);

    do_reset(1'b1, 2'b11);
    ucount = 0;
    for (int i = 0; i < 6; i++) begin
      drive(i, 1'b1, 2'b11);
      if (ifa.update) ucount++;
    end
    chk("t7_noupd", 32'(ucount), 32'd0);
    chk("t7_pos", 32'(ifa.pos), 32'd0);
    for (int i = 0; i < 3; i++) drive(i, 1'b0, 2'b11);
    drive(3, 1'b1, 2'b11);
    chk("t7_upd", 32'(ifa.update), 32'd1);
    chk("t7_pres", 32'(ifa.present), 32'd0);

    v   = 0;
    p   = 2'b00;
    gap = 30;
    vsl = 0;
    for (int i = 0; i < 4000; i++) begin
      for (int c = 0; c < 2; c++) begin
        if ($urandom_range(0, 15) == 0) p[c] = ~p[c];
      end
      if (vsl > 0) begin
        vsl--;
      end else if (gap > 0) begin
        gap--;
      end else begin
        vsl = $urandom_range(1, 4);
        gap = $urandom_range(8, 70);
      end
      rst = ($urandom_range(0, 399) == 0);
      drive(v, vsl > 0, p);
      v = (v + $urandom_range(1, 9)) % 512;
    end
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nerr);
    $finish;
  end

endmodule
